exc_vector_fetch: RTL and testbench

- Exception sequencer that acts as the reader of the exception vector table at memory bytes 253/254/255.
- On an exception it saves the faulting PC into EPC, drives the vector address to memory, waits out the memory latency, and captures the handler byte.
- It then loads the PC with that byte, zero-extended to 32 bits.
- Sits beside the main control FSM; owns the memory address and read strobe only while busy.

---
 rtl/exc_vector_fetch_pkg.sv | 36 +++
 rtl/exc_vector_fetch_if.sv | 21 ++
 rtl/exc_priority_enc.sv | 47 ++++
 rtl/exc_vector_fetch.sv | 160 ++++++++++++++++
 tb/tb_exc_vector_fetch.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_vector_fetch_pkg.sv
// Shared types and constants for the exception vector fetch sequencer.
// Vector table addresses, cause codes and address-mux selects live here.
package exc_vector_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SAVE,
      ADDR,
      WAIT,
      LOAD
   } state_e;

   localparam logic [31:0] VEC_OPCODE_ADDR   = 32'd253;
   localparam logic [31:0] VEC_OVERFLOW_ADDR = 32'd254;
   localparam logic [31:0] VEC_DIV0_ADDR     = 32'd255;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_OPCODE   = 2'd1,
      CAUSE_OVERFLOW = 2'd2,
      CAUSE_DIV0     = 2'd3
   } cause_e;

   // Address mux selects shared with the main control FSM
   localparam logic [2:0] SEL_NONE         = 3'd0;
   localparam logic [2:0] SEL_VEC_OPCODE   = 3'd2;
   localparam logic [2:0] SEL_VEC_OVERFLOW = 3'd3;
   localparam logic [2:0] SEL_VEC_DIV0     = 3'd4;

   typedef struct packed {
      logic        valid;
      logic [31:0] vec;
      cause_e      cause;
   } exc_req_t;

endpackage

// File: rtl/exc_vector_fetch_if.sv
// Memory read port used by the exception vector fetch sequencer.
// master drives address/strobe, slave returns read data.
interface exc_vector_fetch_if;

   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data_in;

   modport master (
      output mem_addr,
      output mem_rd,
      input  mem_data_in
   );

   modport slave (
      input  mem_addr,
      input  mem_rd,
      output mem_data_in
   );

endinterface

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder for exception requests.
// opcode beats overflow beats div0; losers are simply dropped.
module exc_priority_enc
   import exc_vector_fetch_pkg::*;
#(
   parameter logic [31:0] VEC_OPCODE   = VEC_OPCODE_ADDR,
   parameter logic [31:0] VEC_OVERFLOW = VEC_OVERFLOW_ADDR,
   parameter logic [31:0] VEC_DIV0     = VEC_DIV0_ADDR
) (
   input  logic     exc_opcode,
   input  logic     exc_overflow,
   input  logic     exc_div0,
   output exc_req_t req
);

   logic [2:0] sel;

   // Pick the winning request, then map its select to a vector address
   always_comb begin
      sel       = SEL_NONE;
      req.valid = exc_opcode | exc_overflow | exc_div0;
      req.cause = CAUSE_NONE;
      req.vec   = 32'd0;
      priority case (1'b1)
         exc_opcode: begin
            sel       = SEL_VEC_OPCODE;
            req.cause = CAUSE_OPCODE;
         end
         exc_overflow: begin
            sel       = SEL_VEC_OVERFLOW;
            req.cause = CAUSE_OVERFLOW;
         end
         exc_div0: begin
            sel       = SEL_VEC_DIV0;
            req.cause = CAUSE_DIV0;
         end
         default: ;
      endcase
      case (sel)
         SEL_VEC_OPCODE:   req.vec = VEC_OPCODE;
         SEL_VEC_OVERFLOW: req.vec = VEC_OVERFLOW;
         SEL_VEC_DIV0:     req.vec = VEC_DIV0;
         default:          req.vec = 32'd0;
      endcase
   end

endmodule

// File: rtl/exc_vector_fetch.sv
// Exception sequencer: saves EPC, reads the vector table, loads PC.
// Define EXC_CAUSE_EN to add the cause_out register and port.
module exc_vector_fetch
   import exc_vector_fetch_pkg::*;
#(
   parameter int unsigned MEM_LATENCY  = 2,
   parameter logic [31:0] VEC_OPCODE   = VEC_OPCODE_ADDR,
   parameter logic [31:0] VEC_OVERFLOW = VEC_OVERFLOW_ADDR,
   parameter logic [31:0] VEC_DIV0     = VEC_DIV0_ADDR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                exc_opcode,
   input  logic                exc_overflow,
   input  logic                exc_div0,
   input  logic [31:0]         pc_in,
   exc_vector_fetch_if.master  mem,
   output logic [31:0]         epc_out,
   output logic [31:0]         pc_out,
   output logic                pc_load,
   output logic                busy
`ifdef EXC_CAUSE_EN
   ,
   output logic [1:0]          cause_out
`endif
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

   exc_req_t    req;
   state_e      state_q, state_d;
   logic [31:0] vec_q, vec_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] pc_q, pc_d;
   logic        pc_load_q, pc_load_d;
   logic        busy_q, busy_d;
   logic        unused_data_hi;

`ifdef EXC_CAUSE_EN
   cause_e      cause_q, cause_d;
`else
   logic        unused_cause;
   assign unused_cause = ^req.cause;
`endif

   assign unused_data_hi = ^mem.mem_data_in[31:8];

   exc_priority_enc #(
      .VEC_OPCODE   (VEC_OPCODE),
      .VEC_OVERFLOW (VEC_OVERFLOW),
      .VEC_DIV0     (VEC_DIV0)
   ) u_prio (
      .exc_opcode   (exc_opcode),
      .exc_overflow (exc_overflow),
      .exc_div0     (exc_div0),
      .req          (req)
   );

   // Sequencer next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      epc_d      = epc_q;
      pc_d       = pc_q;
      pc_load_d  = 1'b0;
      busy_d     = busy_q;
`ifdef EXC_CAUSE_EN
      cause_d    = cause_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req.valid) begin
               state_d = SAVE;
               vec_d   = req.vec;
               epc_d   = pc_in;
               busy_d  = 1'b1;
`ifdef EXC_CAUSE_EN
               cause_d = req.cause;
`endif
            end
         end
         SAVE: begin
            state_d    = ADDR;
            mem_addr_d = vec_q;
            mem_rd_d   = 1'b1;
         end
         ADDR: begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d    = LOAD;
               pc_d       = {24'b0, mem.mem_data_in[7:0]};
               pc_load_d  = 1'b1;
               mem_addr_d = 32'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         LOAD: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d    = IDLE;
            mem_addr_d = 32'd0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any sequence at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         vec_q      <= 32'd0;
         cnt_q      <= 3'd0;
         mem_addr_q <= 32'd0;
         mem_rd_q   <= 1'b0;
         epc_q      <= 32'd0;
         pc_q       <= 32'd0;
         pc_load_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef EXC_CAUSE_EN
         cause_q    <= CAUSE_NONE;
`endif
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         epc_q      <= epc_d;
         pc_q       <= pc_d;
         pc_load_q  <= pc_load_d;
         busy_q     <= busy_d;
`ifdef EXC_CAUSE_EN
         cause_q    <= cause_d;
`endif
      end
   end

   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_rd   = mem_rd_q;
   assign epc_out      = epc_q;
   assign pc_out       = pc_q;
   assign pc_load      = pc_load_q;
   assign busy         = busy_q;
`ifdef EXC_CAUSE_EN
   assign cause_out    = cause_q;
`endif

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Bench for exc_vector_fetch: directed cases plus random requests
// checked against a cycle-window model of one exception sequence.
module tb_exc_vector_fetch;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_opcode;
   logic        exc_overflow;
   logic        exc_div0;
   logic [31:0] pc_in;
   logic [31:0] epc_out;
   logic [31:0] pc_out;
   logic        pc_load;
   logic        busy;
`ifdef EXC_CAUSE_EN
   logic [1:0]  cause_out;
`endif

   exc_vector_fetch_if bus ();

   exc_vector_fetch #(
      .MEM_LATENCY (LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .exc_opcode   (exc_opcode),
      .exc_overflow (exc_overflow),
      .exc_div0     (exc_div0),
      .pc_in        (pc_in),
      .mem          (bus),
      .epc_out      (epc_out),
      .pc_out       (pc_out),
      .pc_load      (pc_load),
      .busy         (busy)
`ifdef EXC_CAUSE_EN
      ,
      .cause_out    (cause_out)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_word [253:255];
   int          rd_age;

   // Memory: data for the held address becomes valid LAT cycles after mem_rd
   always @(posedge clk or posedge reset) begin
      if (reset)
         rd_age <= 0;
      else if (bus.mem_rd)
         rd_age <= 1;
      else if (rd_age != 0 && bus.mem_addr != 32'd0 && rd_age < 100)
         rd_age <= rd_age + 1;
      else
         rd_age <= 0;
   end

   // Return garbage whenever the read data is not yet valid
   always @(negedge clk) begin
      if (rd_age >= LAT && bus.mem_addr >= 32'd253 && bus.mem_addr <= 32'd255)
         bus.mem_data_in = mem_word[bus.mem_addr];
      else
         bus.mem_data_in = $urandom;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One exception request; optional extra pulse on line inj_line at cycle inj_cyc
   task automatic run_exc(input string name, input bit o, input bit v,
                          input bit d, input logic [31:0] pc,
                          input int inj_cyc, input int inj_line);
      logic [31:0] exp_vec;
      logic [31:0] exp_pc;
      logic [31:0] exp_addr;
      logic [31:0] rd_addr;
      logic [31:0] pc_at_load;
      logic [1:0]  exp_cause;
      logic [1:0]  cause_save;
      int          rd_cnt;
      int          load_cnt;
      int          load_cyc;
      int          busy_cnt;
      int          addr_bad;
      if (o) begin
         exp_vec = 32'd253; exp_cause = 2'd1;
      end else if (v) begin
         exp_vec = 32'd254; exp_cause = 2'd2;
      end else begin
         exp_vec = 32'd255; exp_cause = 2'd3;
      end
      exp_pc     = {24'b0, mem_word[exp_vec][7:0]};
      rd_cnt     = 0;
      rd_addr    = 32'd0;
      load_cnt   = 0;
      load_cyc   = -1;
      busy_cnt   = 0;
      addr_bad   = 0;
      pc_at_load = 32'd0;
      cause_save = 2'd0;
      @(negedge clk);
      pc_in        = pc;
      exc_opcode   = o;
      exc_overflow = v;
      exc_div0     = d;
      @(negedge clk);
      for (int cyc = 1; cyc <= 3 + LAT + 4; cyc++) begin
         if (bus.mem_rd) begin
            rd_cnt++;
            rd_addr = bus.mem_addr;
         end
         exp_addr = (cyc >= 2 && cyc <= 2 + LAT) ? exp_vec : 32'd0;
         if (bus.mem_addr !== exp_addr) addr_bad++;
         if (pc_load) begin
            load_cnt++;
            load_cyc   = cyc;
            pc_at_load = pc_out;
         end
         if (busy) busy_cnt++;
`ifdef EXC_CAUSE_EN
         if (cyc == 1) cause_save = cause_out;
`endif
         exc_opcode   = (cyc == inj_cyc && inj_line == 0);
         exc_overflow = (cyc == inj_cyc && inj_line == 1);
         exc_div0     = (cyc == inj_cyc && inj_line == 2);
         @(negedge clk);
      end
      exc_opcode   = 1'b0;
      exc_overflow = 1'b0;
      exc_div0     = 1'b0;
      check({name, ".rd_count"},  32'(rd_cnt), 32'd1);
      check({name, ".rd_addr"},   rd_addr, exp_vec);
      check({name, ".addr_win"},  32'(addr_bad), 32'd0);
      check({name, ".load_cnt"},  32'(load_cnt), 32'd1);
      check({name, ".load_cyc"},  32'(load_cyc), 32'(3 + LAT));
      check({name, ".pc_load"},   pc_at_load, exp_pc);
      check({name, ".pc_hold"},   pc_out, exp_pc);
      check({name, ".epc"},       epc_out, pc);
      check({name, ".busy_cyc"},  32'(busy_cnt), 32'(3 + LAT));
      check({name, ".busy_end"},  32'(busy), 32'd0);
`ifdef EXC_CAUSE_EN
      check({name, ".cause_save"}, 32'(cause_save), 32'(exp_cause));
      check({name, ".cause_hold"}, 32'(cause_out), 32'(exp_cause));
`else
      cause_save = exp_cause;
`endif
   endtask

   task automatic check_idle_zero(input string name);
      check({name, ".mem_addr"}, bus.mem_addr, 32'd0);
      check({name, ".mem_rd"},   32'(bus.mem_rd), 32'd0);
      check({name, ".epc"},      epc_out, 32'd0);
      check({name, ".pc_out"},   pc_out, 32'd0);
      check({name, ".pc_load"},  32'(pc_load), 32'd0);
      check({name, ".busy"},     32'(busy), 32'd0);
`ifdef EXC_CAUSE_EN
      check({name, ".cause"},    32'(cause_out), 32'd0);
`endif
   endtask

   initial begin
      int late_loads;
      int late_busy;
      bit [2:0] f;
      int inj;
      reset        = 1'b1;
      exc_opcode   = 1'b0;
      exc_overflow = 1'b0;
      exc_div0     = 1'b0;
      pc_in        = 32'd0;
      for (int i = 253; i <= 255; i++) mem_word[i] = $urandom;
      #12;
      check_idle_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      mem_word[253] = 32'h0000_00A7;
      run_exc("opcode", 1, 0, 0, 32'h40, 0, 0);

      mem_word[254] = 32'h0000_003C;
      mem_word[255] = 32'h0000_0099;
      run_exc("ovf_div0", 0, 1, 1, 32'h1000, 0, 0);

      mem_word[253] = 32'h0000_0055;
      run_exc("lockout", 1, 0, 0, 32'h2222, 3, 2);

      mem_word[253] = 32'hFFFF_FF10;
      run_exc("upper", 1, 0, 0, 32'h80, 0, 0);

      // Reset asserted asynchronously while the sequencer is in WAIT
      @(negedge clk);
      pc_in      = 32'h1234;
      exc_opcode = 1'b1;
      @(negedge clk);
      exc_opcode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_idle_zero("midreset");
      #1 reset = 1'b0;
      late_loads = 0;
      late_busy  = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (pc_load) late_loads++;
         if (busy) late_busy++;
      end
      check("midreset.no_load", 32'(late_loads), 32'd0);
      check("midreset.no_busy", 32'(late_busy), 32'd0);

      mem_word[254] = 32'hABCD_EF42;
      run_exc("after_reset", 0, 1, 0, 32'h5000, 0, 0);

      mem_word[255] = 32'h0000_00C3;
      run_exc("div0", 0, 0, 1, 32'h6000, 0, 0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 253; i <= 255; i++) mem_word[i] = $urandom;
         f   = 3'($urandom_range(1, 7));
         inj = $urandom_range(0, 3 + LAT);
         run_exc("rand", f[2], f[1], f[0], $urandom, inj,
                 $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
